// File: rtl/led_pattern_sm.sv
// rtl/led_pattern_sm.sv - multi-mode LED pattern generator (three blink rates plus walking-one chase)
// Mode FSM with auto-advance dwell timer, direct mode load and pattern pause.
module led_pattern_sm #(
  parameter int NUM_LEDS     = 4,
  parameter int HALF_P0      = 1250000,
  parameter int HALF_P1      = 2500000,
  parameter int HALF_P2      = 5000000,
  parameter int HALF_P3      = 2500000,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                auto_en,
  input  logic                mode_load,
  input  logic [1:0]          mode_sel,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic                mode_tick
);

  localparam int MAX_01  = (HALF_P0 > HALF_P1) ? HALF_P0 : HALF_P1;
  localparam int MAX_23  = (HALF_P2 > HALF_P3) ? HALF_P2 : HALF_P3;
  localparam int MAX_H   = (MAX_01 > MAX_23) ? MAX_01 : MAX_23;
  localparam int STEP_W  = $clog2(MAX_H);
  localparam int DWELL_W = $clog2(DWELL_CYCLES);

  localparam logic [1:0] MODE0 = 2'd0;
  localparam logic [1:0] MODE1 = 2'd1;
  localparam logic [1:0] MODE2 = 2'd2;
  localparam logic [1:0] MODE3 = 2'd3;

  localparam logic [STEP_W-1:0]   H0_M1    = STEP_W'(HALF_P0 - 1);
  localparam logic [STEP_W-1:0]   H1_M1    = STEP_W'(HALF_P1 - 1);
  localparam logic [STEP_W-1:0]   H2_M1    = STEP_W'(HALF_P2 - 1);
  localparam logic [STEP_W-1:0]   H3_M1    = STEP_W'(HALF_P3 - 1);
  localparam logic [DWELL_W-1:0]  DWELL_M1 = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] LED_ONE  = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  logic [1:0]          r_mode;
  logic [NUM_LEDS-1:0] r_led;
  logic                r_tick;
  logic                r_phase;
  logic [STEP_W-1:0]   r_step;
  logic [DWELL_W-1:0]  r_dwell;

  logic [STEP_W-1:0]   w_half_m1;
  logic                w_step_done;
  logic                w_dwell_done;
  logic                w_change;
  logic [1:0]          w_next_mode;

  always_comb begin
    w_half_m1 = H0_M1;
    case (r_mode)
      MODE0:   w_half_m1 = H0_M1;
      MODE1:   w_half_m1 = H1_M1;
      MODE2:   w_half_m1 = H2_M1;
      MODE3:   w_half_m1 = H3_M1;
      default: w_half_m1 = H0_M1;
    endcase
  end

  // A load always beats dwell expiry; the loaded mode replaces the advance.
  assign w_step_done  = (r_step == w_half_m1);
  assign w_dwell_done = auto_en && !pause && (r_dwell == DWELL_M1);
  assign w_change     = mode_load || w_dwell_done;
  assign w_next_mode  = mode_load ? mode_sel : (r_mode + 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= MODE0;
      r_led   <= '0;
      r_tick  <= 1'b0;
      r_phase <= 1'b0;
      r_step  <= '0;
      r_dwell <= '0;
    end else if (w_change) begin
      r_mode  <= w_next_mode;
      r_tick  <= 1'b1;
      r_phase <= 1'b0;
      r_step  <= '0;
      r_dwell <= '0;
      r_led   <= (w_next_mode == MODE3) ? LED_ONE : '0;
    end else begin
      r_tick <= 1'b0;
      if (!pause) begin
        if (w_step_done) begin
          r_step  <= '0;
          r_phase <= ~r_phase;
          if (r_mode == MODE3) begin
            r_led <= {r_led[NUM_LEDS-2:0], r_led[NUM_LEDS-1]};
          end else begin
            r_led <= {NUM_LEDS{~r_phase}};
          end
        end else begin
          r_step <= r_step + STEP_W'(1);
        end
      end
      if (!auto_en) begin
        r_dwell <= '0;
      end else if (!pause) begin
        r_dwell <= r_dwell + DWELL_W'(1);
      end
    end
  end

  assign led       = r_led;
  assign mode      = r_mode;
  assign mode_tick = r_tick;

endmodule

// File: tb/tb_led_pattern_sm.sv
// tb/tb_led_pattern_sm.sv - directed and random checks of led_pattern_sm against an elapsed-time model
module tb_led_pattern_sm;

  localparam int N     = 4;
  localparam int DWELL = 40;
  int HP[4] = '{4, 6, 8, 3};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         auto_en = 1'b0;
  logic         mode_load = 1'b0;
  logic [1:0]   mode_sel = 2'd0;
  logic         pause = 1'b0;
  logic [N-1:0] led;
  logic [1:0]   mode;
  logic         mode_tick;

  int vectors = 0;
  int miscompares = 0;

  // Model: mode, active (unpaused) cycles spent in the mode, dwell cycles elapsed.
  int m_mode = 0;
  int m_t = 0;
  int m_d = 0;
  bit m_tick = 0;

  led_pattern_sm #(
    .NUM_LEDS(N), .HALF_P0(4), .HALF_P1(6), .HALF_P2(8), .HALF_P3(3), .DWELL_CYCLES(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .auto_en(auto_en), .mode_load(mode_load), .mode_sel(mode_sel),
    .pause(pause), .led(led), .mode(mode), .mode_tick(mode_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_led();
    int k;
    k = m_t / HP[m_mode];
    if (m_mode == 3) return N'(1 << (k % N));
    return (k % 2 == 1) ? {N{1'b1}} : {N{1'b0}};
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic compare_model();
    check("led", led, exp_led());
    check("mode", {2'b00, mode}, 4'(m_mode));
    check("mode_tick", {3'b000, mode_tick}, {3'b000, m_tick});
  endtask

  task automatic step(input logic a, input logic l, input logic [1:0] s, input logic p, input logic r);
    auto_en = a; mode_load = l; mode_sel = s; pause = p; rst = r;
    @(posedge clk);
    if (r) begin
      m_mode = 0; m_t = 0; m_d = 0; m_tick = 0;
    end else if (l) begin
      m_mode = s; m_t = 0; m_d = 0; m_tick = 1;
    end else if (a && !p && m_d == DWELL - 1) begin
      m_mode = (m_mode + 1) % 4; m_t = 0; m_d = 0; m_tick = 1;
    end else begin
      m_tick = 0;
      if (!p) m_t++;
      if (!a) m_d = 0;
      else if (!p) m_d++;
    end
    @(negedge clk);
    mode_load = 1'b0; rst = 1'b0;
    compare_model();
  endtask

  // Leaves the bench observing cycle 0 (first cycle after rst is released).
  task automatic do_reset(input logic a);
    step(a, 1'b0, 2'd0, 1'b0, 1'b1);
    check("reset_led", led, 4'h0);
    check("reset_mode", {2'b00, mode}, 4'h0);
    check("reset_tick", {3'b000, mode_tick}, 4'h0);
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b0);

    // Blink mode 0 without auto-advance.
    for (int c = 1; c <= 11; c++) begin
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      if (c == 4) check("p1_led_c4", led, 4'hF);
      if (c == 8) check("p1_led_c8", led, 4'h0);
    end

    // Auto-advance through all modes and wrap.
    do_reset(1'b1);
    for (int c = 1; c <= 161; c++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      if (c == 40) check("p2_mode_c40", {2'b00, mode}, 4'h1);
      if (c == 40) check("p2_tick_c40", {3'b000, mode_tick}, 4'h1);
      if (c == 46) check("p2_led_c46", led, 4'hF);
      if (c == 160) check("p2_mode_c160", {2'b00, mode}, 4'h0);
    end

    // Chase via load.
    do_reset(1'b0);
    for (int c = 1; c <= 10; c++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    check("p3_led_c11", led, 4'h1);
    check("p3_mode_c11", {2'b00, mode}, 4'h3);
    for (int c = 12; c <= 23; c++) begin
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
      if (c == 14) check("p3_led_c14", led, 4'h2);
      if (c == 20) check("p3_led_c20", led, 4'h8);
      if (c == 23) check("p3_led_c23", led, 4'h1);
    end

    // Load colliding with dwell expiry.
    do_reset(1'b1);
    for (int c = 1; c <= 39; c++) step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
    check("p4_mode_c40", {2'b00, mode}, 4'h2);
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("p4_tick_c41", {3'b000, mode_tick}, 4'h0);
    for (int c = 42; c <= 80; c++) step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    check("p4_mode_c80", {2'b00, mode}, 4'h3);

    // Pause during cycles 5..14.
    do_reset(1'b1);
    for (int c = 0; c < 50; c++) begin
      step(1'b1, 1'b0, 2'd0, (c >= 5 && c <= 14), 1'b0);
      if (c + 1 == 15) check("p5_led_c15", led, 4'hF);
      if (c + 1 == 18) check("p5_led_c18", led, 4'h0);
      if (c + 1 == 49) check("p5_mode_c49", {2'b00, mode}, 4'h0);
      if (c + 1 == 50) check("p5_mode_c50", {2'b00, mode}, 4'h1);
    end

    // Reset mid-chase.
    do_reset(1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    for (int c = 2; c <= 7; c++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check("p6_led_pre", led, 4'h4);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    check("p6_led_rst", led, 4'h0);
    check("p6_mode_rst", {2'b00, mode}, 4'h0);
    for (int c = 1; c <= 4; c++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    check("p6_led_after", led, 4'hF);

    // Randomized traffic.
    do_reset(1'b1);
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
